// File: rtl/fp_div_round_pack.sv
// Binary32 divider back end: special cases, normalize, round-to-nearest-even,
// range checks and packing, behind a 2-stage valid/ready pipeline.
module fp_div_round_pack (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [25:0] in_quot,
    input  logic        in_rem_nz,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    typedef enum logic [2:0] {
        SP_NONE,
        SP_NAN,
        SP_INVALID,
        SP_INF,
        SP_DIVZERO,
        SP_ZERO
    } spec_t;

    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    spec_t       spec;
    logic signed [9:0] e_raw;
    logic signed [9:0] e_norm;
    logic [23:0] m_norm;
    logic        g_norm;
    logic        s_norm;

    logic        s1_valid;
    logic        s1_sign;
    logic signed [9:0] s1_e;
    logic [23:0] s1_m;
    logic        s1_g;
    logic        s1_s;
    spec_t       s1_spec;

    logic        s2_en;
    logic        round_up;
    logic        carry;
    logic [22:0] frac;
    logic signed [9:0] e_rnd;
    logic        inexact;
    logic [31:0] res;
    logic [4:0]  flags;

    assign a_exp  = in_a[30:23];
    assign b_exp  = in_b[30:23];
    assign a_nan  = (&a_exp) && (|in_a[22:0]);
    assign b_nan  = (&b_exp) && (|in_b[22:0]);
    assign a_inf  = (&a_exp) && !(|in_a[22:0]);
    assign b_inf  = (&b_exp) && !(|in_b[22:0]);
    // Subnormal operands are flushed: only the exponent decides zero.
    assign a_zero = (a_exp == 8'd0);
    assign b_zero = (b_exp == 8'd0);

    always_comb begin
        spec = SP_NONE;
        if (a_nan || b_nan)
            spec = SP_NAN;
        else if ((a_zero && b_zero) || (a_inf && b_inf))
            spec = SP_INVALID;
        else if (a_inf)
            spec = SP_INF;
        else if (b_zero)
            spec = SP_DIVZERO;
        else if (a_zero || b_inf)
            spec = SP_ZERO;
    end

    assign e_raw = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                 + 10'sd127;

    always_comb begin
        m_norm = in_quot[25:2];
        g_norm = in_quot[1];
        s_norm = in_quot[0] | in_rem_nz;
        e_norm = e_raw;
        if (!in_quot[25]) begin
            m_norm = in_quot[24:1];
            g_norm = in_quot[0];
            s_norm = in_rem_nz;
            e_norm = e_raw - 10'sd1;
        end
    end

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign s2_en    = !out_valid || out_ready;

    assign round_up = s1_g && (s1_s || s1_m[0]);
    // Fraction wraps to zero on carry-out, which is exactly 0x800000.
    assign carry    = round_up && (&s1_m);
    assign frac     = s1_m[22:0] + {22'd0, round_up};
    assign e_rnd    = carry ? s1_e + 10'sd1 : s1_e;
    assign inexact  = s1_g | s1_s;

    always_comb begin
        res   = 32'd0;
        flags = 5'd0;
        unique case (s1_spec)
            SP_NAN: res = 32'h7FC00000;
            SP_INVALID: begin
                res   = 32'h7FC00000;
                flags = 5'b10000;
            end
            SP_INF: res = {s1_sign, 8'hFF, 23'd0};
            SP_DIVZERO: begin
                res   = {s1_sign, 8'hFF, 23'd0};
                flags = 5'b01000;
            end
            SP_ZERO: res = {s1_sign, 31'd0};
            default: begin
                if (e_rnd >= 10'sd255) begin
                    res   = {s1_sign, 8'hFF, 23'd0};
                    flags = 5'b00101;
                end else if (e_rnd <= 10'sd0) begin
                    res   = {s1_sign, 31'd0};
                    flags = 5'b00011;
                end else begin
                    res   = {s1_sign, e_rnd[7:0], frac};
                    flags = {4'd0, inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_e       <= 10'sd0;
            s1_m       <= 24'd0;
            s1_g       <= 1'b0;
            s1_s       <= 1'b0;
            s1_spec    <= SP_NONE;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 5'd0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_a[31] ^ in_b[31];
                    s1_e    <= e_norm;
                    s1_m    <= m_norm;
                    s1_g    <= g_norm;
                    s1_s    <= s_norm;
                    s1_spec <= spec;
                end
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res;
                    out_flags  <= flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Directed bench for fp_div_round_pack: arithmetic, special cases,
// range limits, backpressure and asynchronous reset.
module tb_fp_div_round_pack;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [25:0] in_quot;
    logic        in_rem_nz;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int total;
    int bad;

    fp_div_round_pack dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_quot    (in_quot),
        .in_rem_nz  (in_rem_nz),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [25:0] q, input logic r,
                         output logic [31:0] res, output logic [4:0] fl,
                         output int lat);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_quot   = q;
        in_rem_nz = r;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 99;
        res = 32'd0;
        fl  = 5'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                res = out_result;
                fl  = out_flags;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn      = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_quot   = 26'd0;
        in_rem_nz = 1'b0;
        out_ready = 1'b0;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b r=%h f=%b want 0/0/0",
                     out_valid, out_result, out_flags);
        end
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        do_op(32'h40C00000, 32'h40000000, 26'h3000000, 1'b0, res, fl, lat);
        total++;
        if (res !== 32'h40400000 || fl !== 5'b00000) begin
            bad++;
            $display("FAIL six_div_two: got %h/%b want 40400000/00000", res, fl);
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL latency: got %0d want 2", lat);
        end
        do_op(32'h3F800000, 32'h40400000, 26'h1555555, 1'b1, res, fl, lat);
        total++;
        if (res !== 32'h3EAAAAAB || fl !== 5'b00001) begin
            bad++;
            $display("FAIL one_div_three: got %h/%b want 3EAAAAAB/00001", res, fl);
        end
    endtask

    task automatic test_special;
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] er [8];
        logic [4:0]  ef [8];
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        va = '{32'h7FC00001, 32'h3F800000, 32'h00000000, 32'h7F800000,
               32'hFF800000, 32'hC0000000, 32'h00400000, 32'h00000000};
        vb = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'hFF800000,
               32'h40000000, 32'h7F800000, 32'h3F800000, 32'h7F800001};
        er = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
               32'hFF800000, 32'h80000000, 32'h00000000, 32'h7FC00000};
        ef = '{5'b00000, 5'b01000, 5'b10000, 5'b10000,
               5'b00000, 5'b00000, 5'b00000, 5'b00000};
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], 26'h3FFFFFF, 1'b1, res, fl, lat);
            total++;
            if (res !== er[i] || fl !== ef[i] || lat !== 2) begin
                bad++;
                $display("FAIL special_%0d: got %h/%b lat=%0d want %h/%b lat=2",
                         i, res, fl, lat, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [25:0] vq [8];
        logic        vr [8];
        logic [31:0] er [8];
        logic [4:0]  ef [8];
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        va = '{32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'h00800000, 32'h7F000000, 32'h7F000000};
        vb = '{32'h00800000, 32'h7F000000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vq = '{26'h2000000, 26'h2000000, 26'h3FFFFFE, 26'h1000001,
               26'h1000003, 26'h2000000, 26'h2000000, 26'h3FFFFFE};
        vr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        er = '{32'h7F800000, 32'h00000000, 32'h40000000, 32'h3F000000,
               32'h3F000002, 32'h00800000, 32'h7F000000, 32'h7F800000};
        ef = '{5'b00101, 5'b00011, 5'b00001, 5'b00001,
               5'b00001, 5'b00000, 5'b00000, 5'b00101};
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], vq[i], vr[i], res, fl, lat);
            total++;
            if (res !== er[i] || fl !== ef[i]) begin
                bad++;
                $display("FAIL range_%0d: got %h/%b want %h/%b",
                         i, res, fl, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [25:0] vq [4];
        logic        vr [4];
        logic [31:0] er [4];
        logic [4:0]  ef [4];
        logic [31:0] held_r;
        logic [4:0]  held_f;
        logic        acc;
        logic        dropped;
        int          idx;
        int          got;
        int          stall;
        int          acc_at_drop;
        va = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hC0000000};
        vb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h7F800000};
        vq = '{26'h3000000, 26'h1555555, 26'h2000000, 26'h2000000};
        vr = '{1'b0, 1'b1, 1'b0, 1'b0};
        er = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h80000000};
        ef = '{5'b00000, 5'b00001, 5'b01000, 5'b00000};
        idx = 0;
        got = 0;
        stall = 0;
        dropped = 1'b0;
        acc_at_drop = -1;
        held_r = 32'd0;
        held_f = 5'd0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = va[0];
        in_b      = vb[0];
        in_quot   = vq[0];
        in_rem_nz = vr[0];
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!in_ready && !dropped) begin
                dropped = 1'b1;
                acc_at_drop = idx;
            end
            if (out_valid && !out_ready) begin
                if (stall == 0) begin
                    held_r = out_result;
                    held_f = out_flags;
                end else begin
                    total++;
                    if (out_result !== held_r || out_flags !== held_f) begin
                        bad++;
                        $display("FAIL stall_stable: got %h/%b want %h/%b",
                                 out_result, out_flags, held_r, held_f);
                    end
                end
                stall++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_result !== er[got] || out_flags !== ef[got]) begin
                    bad++;
                    $display("FAIL b2b_%0d: got %h/%b want %h/%b",
                             got, out_result, out_flags, er[got], ef[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_a      = va[idx];
                in_b      = vb[idx];
                in_quot   = vq[idx];
                in_rem_nz = vr[idx];
            end
            if (stall >= 3) out_ready = 1'b1;
        end
        total++;
        if (!dropped || acc_at_drop !== 2) begin
            bad++;
            $display("FAIL in_ready_drop: got accepts=%0d want 2", acc_at_drop);
        end
        total++;
        if (got !== 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 4", got);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_extra: got out_valid=%b want 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_inflight;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h40C00000;
        in_b      = 32'h40000000;
        in_quot   = 26'h3000000;
        in_rem_nz = 1'b0;
        @(posedge clk);
        #1;
        in_a      = 32'h3F800000;
        in_b      = 32'h40400000;
        in_quot   = 26'h1555555;
        in_rem_nz = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_result !== 32'h40400000) begin
            bad++;
            $display("FAIL inflight_setup: got %b/%h want 1/40400000",
                     out_valid, out_result);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 5'd0) begin
            bad++;
            $display("FAIL async_reset: got %b/%h/%b want 0/0/0",
                     out_valid, out_result, out_flags);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stale_after_reset: got v=%b rdy=%b want 0/1",
                         out_valid, in_ready);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_special();
        test_range();
        test_back_to_back();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
